// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control inputs and ROM-side outputs of the program-counter unit
interface pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              br_flag;
    logic [ADDR_W-1:0] br_target;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              redir_pend;
    modport master (
        output stall, br_flag, br_target, flush, new_pc,
        input  pc, ce, redir_pend
    );
    modport slave (
        input  stall, br_flag, br_target, flush, new_pc,
        output pc, ce, redir_pend
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with reset vector, stall, branch, buffered redirect and flush
module pc_unit #(
    parameter int              ADDR_W     = 32,
    parameter int              INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] MASK   = ~(STEP - 1'b1);
    localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC & MASK;
    typedef enum logic {S_RST, S_RUN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pend;
    // rst is active-low; the first enabled fetch after release is RST_PC
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state          <= S_RST;
            bus.pc         <= RST_PC;
            bus.ce         <= 1'b0;
            bus.redir_pend <= 1'b0;
            pend           <= '0;
        end else if (state == S_RST) begin
            state  <= S_RUN;
            bus.ce <= 1'b1;
        end else if (bus.flush) begin
            bus.pc         <= bus.new_pc & MASK;
            bus.redir_pend <= 1'b0;
        end else if (bus.stall) begin
            if (bus.br_flag) begin
                pend           <= bus.br_target & MASK;
                bus.redir_pend <= 1'b1;
            end
        end else if (bus.br_flag) begin
            bus.pc         <= bus.br_target & MASK;
            bus.redir_pend <= 1'b0;
        end else if (bus.redir_pend) begin
            bus.pc         <= pend;
            bus.redir_pend <= 1'b0;
        end else
            bus.pc <= bus.pc + STEP;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit (default build plus a 0x1000 / 2-byte build)
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    pc_unit_if #(.ADDR_W(32)) a ();
    pc_unit_if #(.ADDR_W(32)) b ();
    pc_unit #(.ADDR_W(32), .INST_BYTES(4), .RESET_VEC(32'h0)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    pc_unit #(.ADDR_W(32), .INST_BYTES(2), .RESET_VEC(32'h1000)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_a(input string tag, input logic [31:0] p, input logic c, input logic r);
        chk({tag, ".pc"}, a.pc, p);
        chk({tag, ".ce"}, 32'(a.ce), 32'(c));
        chk({tag, ".pend"}, 32'(a.redir_pend), 32'(r));
    endtask
    initial begin
        {a.stall, a.br_flag, a.flush} = '0;
        a.br_target = '0;
        a.new_pc = '0;
        {b.stall, b.br_flag, b.flush} = '0;
        b.br_target = '0;
        b.new_pc = '0;
        #2 rst = 1'b0;
        // T1/T2 reset and first fetches
        repeat (3) step();
        chk_a("rst", 32'h0, 1'b0, 1'b0);
        chk("rst_b.pc", b.pc, 32'h1000);
        chk("rst_b.ce", 32'(b.ce), 32'h0);
        rst = 1'b1;
        step(); chk_a("first", 32'h0, 1'b1, 1'b0);
        chk("first_b.pc", b.pc, 32'h1000);
        chk("first_b.ce", 32'(b.ce), 32'h1);
        step(); chk_a("inc1", 32'h4, 1'b1, 1'b0); chk("inc1_b", b.pc, 32'h1002);
        step(); chk_a("inc2", 32'h8, 1'b1, 1'b0); chk("inc2_b", b.pc, 32'h1004);
        step(); chk_a("inc3", 32'hc, 1'b1, 1'b0);
        step(); chk_a("inc4", 32'h10, 1'b1, 1'b0);
        // T3 branch
        a.br_flag = 1'b1; a.br_target = 32'h80;
        step(); chk_a("br", 32'h80, 1'b1, 1'b0);
        a.br_flag = 1'b0;
        step(); chk_a("br_inc", 32'h84, 1'b1, 1'b0);
        a.br_flag = 1'b1; a.br_target = 32'h83;
        step(); chk_a("br_mask", 32'h80, 1'b1, 1'b0);
        a.br_flag = 1'b0;
        // T4 branches during stall, last one wins
        a.flush = 1'b1; a.new_pc = 32'h20;
        step(); chk_a("to20", 32'h20, 1'b1, 1'b0);
        a.flush = 1'b0; a.stall = 1'b1; a.br_flag = 1'b1; a.br_target = 32'h40;
        step(); chk_a("st1", 32'h20, 1'b1, 1'b1);
        a.br_target = 32'h60;
        step(); chk_a("st2", 32'h20, 1'b1, 1'b1);
        a.br_flag = 1'b0;
        step(); chk_a("st3", 32'h20, 1'b1, 1'b1);
        a.stall = 1'b0;
        step(); chk_a("unstall", 32'h60, 1'b1, 1'b0);
        step(); chk_a("unstall_inc", 32'h64, 1'b1, 1'b0);
        // T5 flush during stall with pending, flush beats branch
        a.stall = 1'b1; a.br_flag = 1'b1; a.br_target = 32'h100;
        step(); chk_a("pend", 32'h64, 1'b1, 1'b1);
        a.br_flag = 1'b0; a.flush = 1'b1; a.new_pc = 32'h200;
        step(); chk_a("flush", 32'h200, 1'b1, 1'b0);
        a.flush = 1'b0; a.stall = 1'b0;
        step(); chk_a("flush_inc", 32'h204, 1'b1, 1'b0);
        a.flush = 1'b1; a.new_pc = 32'h302; a.br_flag = 1'b1; a.br_target = 32'h500;
        step(); chk_a("flush_br", 32'h300, 1'b1, 1'b0);
        a.flush = 1'b0; a.br_flag = 1'b0;
        step(); chk_a("flush_br_inc", 32'h304, 1'b1, 1'b0);
        // current branch beats pending one
        a.stall = 1'b1; a.br_flag = 1'b1; a.br_target = 32'h700;
        step(); chk_a("pend2", 32'h304, 1'b1, 1'b1);
        a.stall = 1'b0; a.br_target = 32'h800;
        step(); chk_a("br_beats", 32'h800, 1'b1, 1'b0);
        a.br_flag = 1'b0;
        step(); chk_a("br_beats_inc", 32'h804, 1'b1, 1'b0);
        // T6 wrap, async reset mid-cycle
        a.flush = 1'b1; a.new_pc = 32'hffff_fffc;
        step(); chk_a("top", 32'hffff_fffc, 1'b1, 1'b0);
        a.flush = 1'b0;
        step(); chk_a("wrap", 32'h0, 1'b1, 1'b0);
        step(); chk_a("wrap_inc", 32'h4, 1'b1, 1'b0);
        a.stall = 1'b1; a.br_flag = 1'b1; a.br_target = 32'h900;
        step(); chk_a("pend3", 32'h4, 1'b1, 1'b1);
        a.stall = 1'b0; a.br_flag = 1'b0;
        #2 rst = 1'b0;
        #1 chk_a("async", 32'h0, 1'b0, 1'b0);
        chk("async_b.pc", b.pc, 32'h1000);
        chk("async_b.ce", 32'(b.ce), 32'h0);
        step(); chk_a("held", 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step(); chk_a("rerun", 32'h0, 1'b1, 1'b0);
        step(); chk_a("lost_pend", 32'h4, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
